// File: rtl/adc_mux_pkg.sv
// Shared constants, FSM state type and sample justification helper for adc_mux.
package adc_mux_pkg;

    localparam int SAMPLE_W = 32;
    localparam int ADC_BITS = 24;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Receivers deliver 24-bit samples MSB-aligned; optionally right-justify with sign.
    function automatic logic [SAMPLE_W-1:0] justify(input logic [SAMPLE_W-1:0] d,
                                                     input logic               en);
        if (en)
            return {{(SAMPLE_W-ADC_BITS){d[SAMPLE_W-1]}}, d[SAMPLE_W-1 -: ADC_BITS]};
        else
            return d;
    endfunction

endpackage

// File: rtl/adc_mux_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] gnt_onehot,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              any
);

    // Scan offsets from farthest to nearest so the nearest request overwrites last.
    always_comb begin
        logic [CH_W-1:0] idx;
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        idx        = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = CH_W'((int'(ptr) + i) % NUM_CH);
            if (req[idx]) begin
                gnt_onehot      = '0;
                gnt_onehot[idx] = 1'b1;
                gnt_idx         = idx;
                any             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_mux.sv
// Round-robin collector of per-channel ADC samples onto one tagged valid/ready stream.
module adc_mux
    import adc_mux_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CH_W    = $clog2(NUM_CH),
    parameter int JUSTIFY = 0
) (
    input  logic                         sck,
    input  logic                         rst,
    input  logic                         start,
    input  logic [NUM_CH-1:0]            adc_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0]   adc_data,
    output logic [NUM_CH-1:0]            adc_ack,
    output logic [SAMPLE_W-1:0]          m_data,
    output logic [CH_W-1:0]              m_ch,
    output logic                         m_last,
    output logic                         m_valid,
    input  logic                         m_ready
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_t                state_q, state_d;
    logic [CH_W-1:0]       ptr_q, ptr_d;
    logic [NUM_CH-1:0]     ack_q, ack_d;
    logic [SAMPLE_W-1:0]   m_data_q, m_data_d;
    logic [CH_W-1:0]       m_ch_q, m_ch_d;
    logic                  m_last_q, m_last_d;
    logic                  m_valid_q, m_valid_d;

    logic [SAMPLE_W-1:0]   ch_data [NUM_CH];
    logic [NUM_CH-1:0]     eligible;
    logic [NUM_CH-1:0]     gnt_onehot;
    logic [CH_W-1:0]       gnt_idx;
    logic                  gnt_any;
    logic                  slot_free;
    logic                  grant;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign ch_data[gi] = adc_data[gi*SAMPLE_W +: SAMPLE_W];
    end

    // A channel whose ack is still high is masked: its flag is only cleared on the next edge.
    assign eligible  = adc_valid & ~ack_q;
    assign slot_free = !m_valid_q || m_ready;
    assign grant     = (state_q == RUN) && slot_free && gnt_any;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req        (eligible),
        .ptr        (ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (gnt_any)
    );

    // Next state: leave IDLE on start, then stay in RUN until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Next output slot, ack pulse and round-robin pointer.
    always_comb begin
        ptr_d     = ptr_q;
        ack_d     = '0;
        m_data_d  = m_data_q;
        m_ch_d    = m_ch_q;
        m_last_d  = m_last_q;
        m_valid_d = m_valid_q;
        if (grant) begin
            ptr_d     = (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
            ack_d     = gnt_onehot;
            m_data_d  = justify(ch_data[gnt_idx], JUSTIFY != 0);
            m_ch_d    = gnt_idx;
            m_last_d  = (gnt_idx == LAST_CH);
            m_valid_d = 1'b1;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge sck) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            ack_q     <= '0;
            m_data_q  <= '0;
            m_ch_q    <= '0;
            m_last_q  <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            ack_q     <= ack_d;
            m_data_q  <= m_data_d;
            m_ch_q    <= m_ch_d;
            m_last_q  <= m_last_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign adc_ack = ack_q;
    assign m_data  = m_data_q;
    assign m_ch    = m_ch_q;
    assign m_last  = m_last_q;
    assign m_valid = m_valid_q;

endmodule

// File: tb/tb_adc_mux.sv
// Directed scoreboard bench for adc_mux (pass-through and right-justified instances).
module tb_adc_mux;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  ch;
        logic        last;
    } exp_t;

    logic         sck = 1'b0;
    logic         rst;
    logic         start, j_start;
    logic [3:0]   adc_valid, j_valid;
    logic [127:0] adc_data, j_data;
    logic [3:0]   adc_ack, j_ack;
    logic [31:0]  m_data, j_m_data;
    logic [1:0]   m_ch, j_m_ch;
    logic         m_last, j_m_last;
    logic         m_valid, j_m_valid;
    logic         m_ready, j_m_ready;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    logic [3:0]  prev_ack0 = '0, prev_ack1 = '0;
    logic [31:0] held;

    always #5 sck = ~sck;

    adc_mux #(.NUM_CH(4), .JUSTIFY(0)) dut0 (
        .sck(sck), .rst(rst), .start(start), .adc_valid(adc_valid), .adc_data(adc_data),
        .adc_ack(adc_ack), .m_data(m_data), .m_ch(m_ch), .m_last(m_last),
        .m_valid(m_valid), .m_ready(m_ready)
    );

    adc_mux #(.NUM_CH(4), .JUSTIFY(1)) dut1 (
        .sck(sck), .rst(rst), .start(j_start), .adc_valid(j_valid), .adc_data(j_data),
        .adc_ack(j_ack), .m_data(j_m_data), .m_ch(j_m_ch), .m_last(j_m_last),
        .m_valid(j_m_valid), .m_ready(j_m_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] d, input logic [1:0] ch);
        exp_t e;
        e.d = d;
        e.ch = ch;
        e.last = (ch == 2'd3);
        return e;
    endfunction

    // One clock: snapshot acks, then after the edge the receivers drop their flags.
    task automatic tick();
        logic [3:0] s0, s1;
        @(negedge sck);
        s0 = adc_ack;
        s1 = j_ack;
        @(posedge sck);
        #1;
        adc_valid = adc_valid & ~s0;
        j_valid   = j_valid & ~s1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Scoreboard monitor for the pass-through instance.
    always @(negedge sck) begin
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            if (q0.size() == 0) begin
                chk("unexpected_word0", {30'd0, m_ch}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q0.pop_front();
                $display("word dut0 ch=%0d data=%h last=%0d", m_ch, m_data, m_last);
                chk("m_data0", m_data, e.d);
                chk("m_ch0", {30'd0, m_ch}, {30'd0, e.ch});
                chk("m_last0", {31'd0, m_last}, {31'd0, e.last});
            end
        end
        if (adc_ack !== 4'b0000 && rst !== 1'b1) begin
            chk("ack_onehot0", {31'd0, $onehot(adc_ack)}, 32'd1);
            chk("ack_single_cycle0", {28'd0, adc_ack & prev_ack0}, 32'd0);
        end
        prev_ack0 = adc_ack;
    end

    // Scoreboard monitor for the right-justified instance.
    always @(negedge sck) begin
        if (j_m_valid === 1'b1 && j_m_ready === 1'b1) begin
            if (q1.size() == 0) begin
                chk("unexpected_word1", {30'd0, j_m_ch}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q1.pop_front();
                $display("word dut1 ch=%0d data=%h last=%0d", j_m_ch, j_m_data, j_m_last);
                chk("m_data1", j_m_data, e.d);
                chk("m_ch1", {30'd0, j_m_ch}, {30'd0, e.ch});
                chk("m_last1", {31'd0, j_m_last}, {31'd0, e.last});
            end
        end
        prev_ack1 = j_ack;
    end

    initial begin
        rst = 1'b1; start = 1'b0; j_start = 1'b1;
        adc_valid = 4'b1111; j_valid = 4'b0000;
        m_ready = 1'b1; j_m_ready = 1'b1;
        j_data = '0;
        for (int c = 0; c < 4; c++) adc_data[c*32 +: 32] = 32'hA000_0000 + (c << 8);

        // Reset and IDLE: no acks, no output, even with every channel valid.
        ticks(3);
        chk("reset_m_valid", {31'd0, m_valid}, 32'd0);
        chk("reset_m_data", m_data, 32'd0);
        chk("reset_ack", {28'd0, adc_ack}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_ack", {28'd0, adc_ack}, 32'd0);
            chk("idle_m_valid", {31'd0, m_valid}, 32'd0);
        end

        // Round robin over all channels; first grant two edges after start.
        for (int c = 0; c < 4; c++) q0.push_back(mk(32'hA000_0000 + (c << 8), 2'(c)));
        start = 1'b1;
        tick();
        chk("start_edge1_m_valid", {31'd0, m_valid}, 32'd0);
        tick();
        chk("start_edge2_m_valid", {31'd0, m_valid}, 32'd1);
        chk("start_edge2_ack", {28'd0, adc_ack}, 32'd1);
        ticks(6);
        chk("rr_idle_after", {31'd0, m_valid}, 32'd0);

        // Single channel: the ack mask must prevent a second capture.
        adc_data[31:0] = 32'h1234_5600;
        adc_valid = 4'b0001;
        q0.push_back(mk(32'h1234_5600, 2'd0));
        ticks(5);

        // Bring ptr to 3, then wrap with only ch1 and ch3 valid.
        adc_data[95:64] = 32'h2222_2200;
        adc_valid = 4'b0100;
        q0.push_back(mk(32'h2222_2200, 2'd2));
        ticks(4);
        adc_data[63:32]  = 32'h1111_1100;
        adc_data[127:96] = 32'h3333_3300;
        adc_valid = 4'b1010;
        q0.push_back(mk(32'h3333_3300, 2'd3));
        q0.push_back(mk(32'h1111_1100, 2'd1));
        ticks(5);

        // Backpressure: ptr is now 2, so order is 2,3,0,1.
        for (int c = 0; c < 4; c++) adc_data[c*32 +: 32] = 32'hB000_0000 + (c << 8);
        m_ready = 1'b0;
        adc_valid = 4'b1111;
        q0.push_back(mk(32'hB000_0200, 2'd2));
        q0.push_back(mk(32'hB000_0300, 2'd3));
        q0.push_back(mk(32'hB000_0000, 2'd0));
        q0.push_back(mk(32'hB000_0100, 2'd1));
        tick();
        chk("bp_first_ch", {30'd0, m_ch}, 32'd2);
        chk("bp_first_ack", {28'd0, adc_ack}, 32'h4);
        held = m_data;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_data", m_data, 32'hB000_0200);
            chk("bp_hold_ch", {30'd0, m_ch}, 32'd2);
            chk("bp_no_ack", {28'd0, adc_ack}, 32'd0);
        end
        chk("bp_held_equal", m_data, held);
        m_ready = 1'b1;
        tick();
        chk("bp_regrant_valid", {31'd0, m_valid}, 32'd1);
        chk("bp_regrant_ch", {30'd0, m_ch}, 32'd3);
        tick();
        chk("bp_cont_valid_a", {31'd0, m_valid}, 32'd1);
        tick();
        chk("bp_cont_valid_b", {31'd0, m_valid}, 32'd1);
        tick();
        chk("bp_drained", {31'd0, m_valid}, 32'd0);
        ticks(2);

        // Reset mid-stream: ptr is 2, only ch1 valid, hold the word with m_ready low.
        m_ready = 1'b0;
        adc_data[63:32] = 32'hC000_0100;
        adc_valid = 4'b0010;
        tick();
        chk("pre_rst_valid", {31'd0, m_valid}, 32'd1);
        chk("pre_rst_ack", {28'd0, adc_ack}, 32'h2);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", {31'd0, m_valid}, 32'd0);
        chk("mid_rst_ack", {28'd0, adc_ack}, 32'd0);
        chk("mid_rst_data", m_data, 32'd0);
        rst = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < 4; c++) adc_data[c*32 +: 32] = 32'hD000_0000 + (c << 8);
        adc_valid = 4'b1111;
        for (int c = 0; c < 4; c++) q0.push_back(mk(32'hD000_0000 + (c << 8), 2'(c)));
        ticks(8);

        // Right-justified instance: ch2 then ch3.
        j_data[95:64]  = 32'hFFFF_F000;
        j_data[127:96] = 32'h7FFF_FF00;
        j_valid = 4'b1100;
        q1.push_back(mk(32'hFFFF_FFF0, 2'd2));
        q1.push_back(mk(32'h007F_FFFF, 2'd3));
        ticks(6);

        for (int i = 0; i < 50 && (q0.size() + q1.size()) != 0; i++) tick();
        chk("queues_drained", q0.size() + q1.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
